// File: rtl/aes_sram_pkg.sv
// Shared types and constants for the SRAM-to-AES block reader.
package aes_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  localparam int BLK_BYTES     = 16;
  localparam int WORDS_PER_BLK = 4;
  localparam int SRAM_AW_DEF   = 11;

endpackage

// File: rtl/axi_sram_block_reader.sv
// Fetches 16-byte blocks over AXI4-Lite, one word in flight at a time, and
// presents each as a 128-bit stream beat with error and last flags.
module axi_sram_block_reader
  import aes_sram_pkg::*;
#(
  parameter int AXI_AW  = 32,
  parameter int SRAM_AW = SRAM_AW_DEF
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SRAM_AW-1:0] cmd_addr,
  input  logic [6:0]         cmd_nblk_m1,
  output logic [AXI_AW-1:0]  m_axi_araddr,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  input  logic [31:0]        m_axi_rdata,
  input  logic [1:0]         m_axi_rresp,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready,
  output logic [127:0]       blk_data,
  output logic               blk_err,
  output logic               blk_last,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [SRAM_AW-1:0] base_q, base_d;
  logic [6:0]         nblk_q, nblk_d;
  logic [6:0]         blk_cnt_q, blk_cnt_d;
  logic [1:0]         word_cnt_q, word_cnt_d;
  logic [127:0]       data_q, data_d;
  logic               err_q, err_d;
  logic [SRAM_AW-1:0] rd_off;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      nblk_q     <= '0;
      blk_cnt_q  <= '0;
      word_cnt_q <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      nblk_q     <= nblk_d;
      blk_cnt_q  <= blk_cnt_d;
      word_cnt_q <= word_cnt_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    nblk_d        = nblk_q;
    blk_cnt_d     = blk_cnt_q;
    word_cnt_d    = word_cnt_q;
    data_d        = data_q;
    err_d         = err_q;
    cmd_ready     = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    blk_valid     = 1'b0;

    // Offset is built from registers only, so it cannot move while AR waits.
    rd_off = base_q + SRAM_AW'(BLK_BYTES * int'(blk_cnt_q) + 4 * int'(word_cnt_q));

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = !areset;
        if (cmd_valid) begin
          state_d    = ST_AR;
          base_d     = cmd_addr & ~SRAM_AW'(BLK_BYTES - 1);
          nblk_d     = cmd_nblk_m1;
          blk_cnt_d  = '0;
          word_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      ST_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = ST_R;
      end
      ST_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          data_d[32*word_cnt_q +: 32] = m_axi_rdata;
          err_d      = err_q | (m_axi_rresp != 2'b00);
          word_cnt_d = word_cnt_q + 2'd1;
          state_d    = (word_cnt_q == 2'(WORDS_PER_BLK - 1)) ? ST_OUT : ST_AR;
        end
      end
      ST_OUT: begin
        blk_valid = 1'b1;
        if (blk_ready) begin
          if (blk_cnt_q == nblk_q) begin
            state_d = ST_IDLE;
          end else begin
            blk_cnt_d = blk_cnt_q + 7'd1;
            err_d     = 1'b0;
            state_d   = ST_AR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    m_axi_araddr = AXI_AW'(rd_off);
    blk_data     = data_q;
    blk_err      = err_q;
    blk_last     = (state_q == ST_OUT) && (blk_cnt_q == nblk_q);
    busy         = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_axi_sram_block_reader.sv
// Randomized bench: SRAM/AXI slave model, reference block builder and a
// scoreboard monitor that checks every AR address and every output block.
module tb_axi_sram_block_reader;

  localparam int AW     = 32;
  localparam int SAW    = 11;
  localparam int NWORDS = 512;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [SAW-1:0] cmd_addr = '0;
  logic [6:0]    cmd_nblk_m1 = '0;
  logic [AW-1:0] m_axi_araddr;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [31:0]   m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;
  logic [127:0]  blk_data;
  logic          blk_err;
  logic          blk_last;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic          busy;

  always #5 aclk = ~aclk;

  axi_sram_block_reader #(.AXI_AW(AW), .SRAM_AW(SAW)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_nblk_m1(cmd_nblk_m1),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .blk_data(blk_data), .blk_err(blk_err), .blk_last(blk_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .busy(busy)
  );

  typedef struct {
    logic [127:0] data;
    logic         err;
    logic         last;
  } blk_t;

  logic [31:0] mem     [NWORDS];
  bit          err_mem [NWORDS];
  blk_t        exp_blk_q[$];
  logic [31:0] exp_ar_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // slave / sink state
  int          ar_delay = 0;
  int          ar_wait = 0;
  bit          ar_fire = 0;
  logic [31:0] ar_lat_addr = '0;
  bit          rd_pending = 0;
  logic [31:0] rd_addr = '0;
  bit          r_fire = 0;
  bit          r_stall = 0;
  int          r_cnt = 0;
  int          ar_fires = 0;
  int          hold_req = 0;
  int          hold_cnt = 0;
  bit          hold_release = 0;
  bit          blk_fire = 0;
  bit          blk_fire_last = 0;
  int          blk_done = 0;
  bit          prev_blk_wait = 0;
  logic [127:0] prev_data = '0;
  logic        prev_err = 0;
  logic        prev_last = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: AXI slave, blk sink and scoreboard, all acting on the falling edge.
  always @(negedge aclk) begin
    if (areset) begin
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
      blk_ready = 1'b0;
      ar_fire = 0; r_fire = 0; rd_pending = 0; ar_wait = 0; r_cnt = 0;
      hold_cnt = 0; hold_release = 0; blk_fire = 0; prev_blk_wait = 0;
      exp_ar_q.delete();
      exp_blk_q.delete();
    end else begin
      if (ar_fire) begin
        ar_fire = 0; m_axi_arready = 1'b0; ar_wait = 0;
        rd_pending = 1; rd_addr = ar_lat_addr;
      end
      if (r_fire) begin
        r_fire = 0; m_axi_rvalid = 1'b0; rd_pending = 0; r_cnt++;
        if (r_cnt % 4 == 0) check("blk_valid_after_r4", 128'(blk_valid), 128'(1));
        else                check("arvalid_after_r", 128'(m_axi_arvalid), 128'(1));
      end
      if (blk_fire) begin
        blk_fire = 0;
        if (blk_fire_last) check("idle_after_last", 128'(busy), 128'(0));
        else               check("arvalid_after_blk", 128'(m_axi_arvalid), 128'(1));
      end
      check("rready_only_in_r", 128'(m_axi_rready), 128'(rd_pending));

      if (m_axi_arvalid) begin
        check("ar_single_outstanding", 128'(rd_pending), 128'(0));
        if (ar_wait == 0) ar_lat_addr = m_axi_araddr;
        else check("araddr_held", 128'(m_axi_araddr), 128'(ar_lat_addr));
        if ((ar_delay > 0) ? (ar_wait >= ar_delay) : ($urandom_range(0, 2) == 0)) begin
          m_axi_arready = 1'b1; ar_fire = 1; ar_fires++;
          if (exp_ar_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL ar_unexpected: got araddr %0h expected no read", m_axi_araddr);
          end else begin
            check("araddr", 128'(m_axi_araddr), 128'(exp_ar_q.pop_front()));
          end
        end else begin
          ar_wait++;
        end
      end

      if (rd_pending && !m_axi_rvalid && !r_stall && $urandom_range(0, 1) == 0) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem[rd_addr[10:2]];
        m_axi_rresp  = err_mem[rd_addr[10:2]] ? 2'b10 : 2'b00;
      end
      if (m_axi_rvalid && m_axi_rready) r_fire = 1;

      if (prev_blk_wait) begin
        check("blk_valid_held", 128'(blk_valid), 128'(1));
        check("blk_data_stable", blk_data, prev_data);
        check("blk_err_stable", 128'(blk_err), 128'(prev_err));
        check("blk_last_stable", 128'(blk_last), 128'(prev_last));
      end
      if (blk_valid) begin
        if (hold_req > 0) begin hold_cnt = hold_req; hold_req = 0; end
        if (hold_cnt > 0) begin
          check("no_arvalid_in_hold", 128'(m_axi_arvalid), 128'(0));
          hold_cnt--; blk_ready = 1'b0; hold_release = (hold_cnt == 0);
        end else begin
          blk_ready = hold_release ? 1'b1 : 1'($urandom_range(0, 1));
          hold_release = 0;
        end
        if (blk_ready) begin
          blk_fire = 1; blk_done++; prev_blk_wait = 0;
          if (exp_blk_q.size() == 0) begin
            n_checks++; n_errors++; blk_fire_last = blk_last;
            $display("FAIL blk_unexpected: got block %0h expected none", blk_data);
          end else begin
            blk_t eb;
            eb = exp_blk_q.pop_front();
            blk_fire_last = eb.last;
            check("blk_data", blk_data, eb.data);
            check("blk_err", 128'(blk_err), 128'(eb.err));
            check("blk_last", 128'(blk_last), 128'(eb.last));
          end
        end else begin
          prev_blk_wait = 1; prev_data = blk_data; prev_err = blk_err; prev_last = blk_last;
        end
      end else begin
        prev_blk_wait = 0;
        blk_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference: block b word k comes from (base + 16b + 4k) mod 2048.
  task automatic model_cmd(input logic [SAW-1:0] addr, input int nm1);
    int base;
    base = int'(addr) & 32'h7F0;
    for (int b = 0; b <= nm1; b++) begin
      blk_t eb;
      eb.data = '0; eb.err = 1'b0; eb.last = (b == nm1);
      for (int k = 0; k < 4; k++) begin
        int a;
        a = (base + 16 * b + 4 * k) % 2048;
        exp_ar_q.push_back(32'(a));
        eb.data[32*k +: 32] = mem[a / 4];
        eb.err = eb.err | err_mem[a / 4];
      end
      exp_blk_q.push_back(eb);
    end
  endtask

  task automatic issue(input logic [SAW-1:0] addr, input int nm1);
    bit acc;
    acc = 0;
    model_cmd(addr, nm1);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_nblk_m1 = 7'(nm1);
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (cmd_ready) begin acc = 1; break; end
    end
    check("cmd_accepted", 128'(acc), 128'(1));
    tick();
    cmd_valid = 1'b0;
    @(negedge aclk);
    check("arvalid_after_cmd", 128'(m_axi_arvalid), 128'(1));
  endtask

  task automatic wait_done(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (!busy && exp_blk_q.size() == 0) begin done = 1; break; end
    end
    check("transfer_done", 128'(done), 128'(1));
    check("all_reads_issued", 128'(exp_ar_q.size()), 128'(0));
    tick();
  endtask

  task automatic check_reset_outputs(input string tag, input logic exp_cmd_ready);
    check({tag, "_arvalid"}, 128'(m_axi_arvalid), 128'(0));
    check({tag, "_rready"}, 128'(m_axi_rready), 128'(0));
    check({tag, "_blk_valid"}, 128'(blk_valid), 128'(0));
    check({tag, "_blk_err"}, 128'(blk_err), 128'(0));
    check({tag, "_blk_last"}, 128'(blk_last), 128'(0));
    check({tag, "_blk_data"}, blk_data, 128'(0));
    check({tag, "_araddr"}, 128'(m_axi_araddr), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_cmd_ready"}, 128'(cmd_ready), 128'(exp_cmd_ready));
  endtask

  initial begin
    int rd0, d0;
    bit found;
    for (int i = 0; i < NWORDS; i++) begin mem[i] = $urandom; err_mem[i] = 0; end
    mem[0] = 32'h11111111; mem[1] = 32'h22222222;
    mem[2] = 32'h33333333; mem[3] = 32'h44444444;

    areset = 1'b1;
    repeat (3) tick();
    @(negedge aclk);
    check_reset_outputs("in_reset", 1'b0);
    tick();
    areset = 1'b0;
    @(negedge aclk);
    check("cmd_ready_after_release", 128'(cmd_ready), 128'(1));
    check("busy_after_release", 128'(busy), 128'(0));
    tick();

    // single block from offset 0
    issue(11'h000, 0);
    wait_done(2000);

    // wrap from the top of the window back to offset 0
    issue(11'h7F0, 1);
    wait_done(2000);

    // output back-pressure for 10 cycles on the first block
    hold_req = 10;
    issue(11'h100, 1);
    wait_done(2000);

    // error response on word 2 of block 0 only
    err_mem[2] = 1;
    rd0 = ar_fires;
    issue(11'h000, 1);
    wait_done(2000);
    check("reads_with_error", 128'(ar_fires - rd0), 128'(8));
    err_mem[2] = 0;

    // slow arready, plus commands offered while busy
    ar_delay = 5;
    issue(11'h20C, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      cmd_valid = 1'b1; cmd_addr = 11'h300; cmd_nblk_m1 = 7'd3;
      @(negedge aclk);
      check("cmd_ready_while_busy", 128'(cmd_ready), 128'(0));
    end
    tick();
    cmd_valid = 1'b0;
    wait_done(2000);
    ar_delay = 0;

    // reset while reading block 3 of 8
    d0 = blk_done;
    found = 0;
    issue(11'h040, 7);
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk);
      if (blk_done == d0 + 3) r_stall = 1;
      if (r_stall && m_axi_rready) begin found = 1; break; end
    end
    check("reached_r_block3", 128'(found), 128'(1));
    tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    r_stall = 0;
    @(negedge aclk);
    check_reset_outputs("after_abort", 1'b1);
    repeat (5) tick();
    issue(11'h010, 2);
    wait_done(2000);

    // randomized commands with scattered error words
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NWORDS; i++) err_mem[i] = 0;
      for (int i = 0; i < 3; i++) err_mem[$urandom_range(0, NWORDS - 1)] = 1;
      issue(11'($urandom_range(0, 2047)), $urandom_range(0, 5));
      wait_done(3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_block_reader.md
AXI_SRAM_BLOCK_READER -- requirements
Module: axi_sram_block_reader

Interface
REQ-001 The interface SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter AXI_AW, default 32, SHALL set the AXI address width.
REQ-003 Parameter SRAM_AW, default 11, SHALL set the byte-address span; offsets wrap modulo 2^SRAM_AW.
REQ-004 aclk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 areset  in  1  SHALL be the synchronous active-high reset, sampled on the aclk rising edge.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  SHALL form the command handshake.
REQ-007 cmd_addr  in  SRAM_AW  SHALL give the start byte offset; bits [3:0] are ignored (forced 0).
REQ-008 cmd_nblk_m1  in  7  SHALL give the block count minus one (1..128 blocks).
REQ-009 m_axi_araddr, m_axi_arvalid / m_axi_arready  out AXI_AW, out 1 / in 1  SHALL form the AXI4-Lite AR channel.
REQ-010 m_axi_rdata, m_axi_rresp, m_axi_rvalid / m_axi_rready  in 32, in 2, in 1 / out 1  SHALL form the R channel.
REQ-011 blk_data, blk_err, blk_last, blk_valid / blk_ready  out 128, out 1, out 1, out 1 / in 1  SHALL form the 128-bit AES block output stream.
REQ-012 busy  out  1  SHALL be high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, AR, R, OUT.
- IDLE: cmd_ready=1; on cmd handshake, latch base and count, clear counters, go to AR.
- AR: arvalid=1, araddr stable; on arready go to R.
- R: rready=1; on rvalid capture word, increment word_cnt; go to AR if word_cnt<3, else OUT.
- OUT: blk_valid=1, blk_data stable; on blk_ready go to AR if more blocks remain, else IDLE.
REQ-014 araddr SHALL be zero-extended (base + 16*blk_cnt + 4*word_cnt) mod 2^SRAM_AW.
REQ-015 Word k of a block SHALL land in blk_data[32k+31:32k] (little-endian).
REQ-016 arvalid SHALL assert the cycle after the cmd handshake or after the preceding R/blk handshake; at most one read is outstanding.
REQ-017 arvalid SHALL NOT deassert, and araddr SHALL NOT change, until arready.
REQ-018 rready SHALL be 0 outside R.
REQ-019 blk_valid SHALL assert the cycle after the 4th R handshake and hold until blk_ready.
REQ-020 blk_data/blk_err/blk_last SHALL be stable while blk_valid=1.
REQ-021 blk_err SHALL be the OR of (rresp != 0) over the block's 4 words; the transfer continues regardless.
REQ-022 blk_last SHALL be 1 only on block number cmd_nblk_m1.
REQ-023 cmd_ready SHALL be 0 outside IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-024 Address wrap (e.g. base 0x7F0, 2 blocks) SHALL continue at offset 0x000.
REQ-025 In IDLE, blk_valid, arvalid and rready SHALL be 0.

Reset
REQ-026 While areset=1, the block SHALL force state IDLE, counters 0, and these outputs: arvalid=0, rready=0, blk_valid=0, blk_err=0, blk_last=0, blk_data=0, araddr=0, busy=0.
REQ-027 cmd_ready SHALL be 0 while areset=1 and 1 the first cycle after release.
REQ-028 A reset mid-transfer SHALL abort immediately with no further AXI or blk activity; loss of the in-flight read is accepted.

Structure
REQ-029 Package aes_sram_pkg SHALL hold the state enum, BLK_BYTES=16, WORDS_PER_BLK=4 and the default SRAM_AW.
REQ-030 The block SHALL be a single module with no sub-module; a 2-bit word counter, 7-bit block counter and 128-bit shift/assembly register suffice.

Verification
REQ-031 SRAM words 0x000..0x00C = 11111111,22222222,33333333,44444444; cmd addr 0x000, nblk_m1=0 -> one block 0x44444444_33333333_22222222_11111111 with blk_last=1, blk_err=0, then IDLE.
REQ-032 cmd addr 0x7F0, nblk_m1=1 -> reads 0x7F0..0x7FC then 0x000..0x00C; second block has blk_last=1.
REQ-033 blk_ready held low 10 cycles in OUT -> blk_data stable, no arvalid issued; resumes the cycle after blk_ready=1.
REQ-034 rresp=2'b10 on word 2 of block 0 of 2 -> block 0 blk_err=1, block 1 blk_err=0, all 8 reads issued.
REQ-035 areset pulsed while in R on block 3 of 8 -> next cycle all outputs at reset values, cmd_ready=1; a new cmd completes correctly.
REQ-036 arready delayed 5 cycles -> araddr/arvalid held constant; cmd_valid during busy is not accepted.
